// File: rtl/core_block_ctrl.sv
// core_block_ctrl: per-core block controller. Accepts one block dispatch, steps each
// instruction through FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, and parks in DONE on RET.
//
// Parameters:
//   THREADS_PER_BLOCK - thread lanes per core
//   PC_WIDTH          - program counter width
// Ports:
//   clk             - clock, all state changes on rising edge
//   reset           - synchronous active-low reset
//   start           - dispatch request (honoured only in IDLE)
//   block_id_in     - block index for the dispatch
//   thread_count_in - active thread count, clamped to THREADS_PER_BLOCK
//   instr_valid     - fetcher delivered instruction at current_pc
//   instr_ret       - decoded instruction is RET
//   lsu_waiting     - per-lane outstanding memory operation
//   next_pc         - PC from the branch unit
//   core_state      - FSM state (IDLE=0 .. DONE=7)
//   thread_enable   - active lane mask
//   current_pc      - PC of the instruction in flight
//   block_id        - latched block index
//   done            - block complete
//   cycle_count     - busy-cycle counter, present only with CORE_CYCLE_COUNT_EN defined
module core_block_ctrl #(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned PC_WIDTH          = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [7:0]                             block_id_in,
  input  logic [$clog2(THREADS_PER_BLOCK):0]     thread_count_in,
  input  logic                                   instr_valid,
  input  logic                                   instr_ret,
  input  logic [THREADS_PER_BLOCK-1:0]           lsu_waiting,
  input  logic [PC_WIDTH-1:0]                    next_pc,
  output logic [2:0]                             core_state,
  output logic [THREADS_PER_BLOCK-1:0]           thread_enable,
  output logic [PC_WIDTH-1:0]                    current_pc,
  output logic [7:0]                             block_id,
`ifdef CORE_CYCLE_COUNT_EN
  output logic                                   done,
  output logic [15:0]                            cycle_count
`else
  output logic                                   done
`endif
);

  localparam int unsigned TCW = $clog2(THREADS_PER_BLOCK) + 1;
  localparam logic [TCW-1:0] LP_MAX = TCW'(THREADS_PER_BLOCK);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StRequest = 3'd3,
    StWait    = 3'd4,
    StExecute = 3'd5,
    StUpdate  = 3'd6,
    StDone    = 3'd7
  } state_e;

  state_e                       r_state, w_state_next;
  logic [THREADS_PER_BLOCK-1:0] r_thread_enable, w_thread_enable_next;
  logic [PC_WIDTH-1:0]          r_pc, w_pc_next;
  logic [7:0]                   r_block_id, w_block_id_next;
  logic                         r_done, w_done_next;

  logic [TCW-1:0]               w_count;
  logic [THREADS_PER_BLOCK-1:0] w_mask;

  // Clamp the requested count, then expand it to a low-justified lane mask.
  always_comb begin
    w_count = (thread_count_in > LP_MAX) ? LP_MAX : thread_count_in;
    w_mask  = '0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      w_mask[i] = (TCW'(i) < w_count);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= StIdle;
      r_thread_enable <= '0;
      r_pc            <= '0;
      r_block_id      <= '0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_thread_enable <= w_thread_enable_next;
      r_pc            <= w_pc_next;
      r_block_id      <= w_block_id_next;
      r_done          <= w_done_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_thread_enable_next = r_thread_enable;
    w_pc_next            = r_pc;
    w_block_id_next      = r_block_id;
    w_done_next          = r_done;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_block_id_next      = block_id_in;
          w_thread_enable_next = w_mask;
          w_pc_next            = '0;
          // An empty block completes immediately without running any instruction.
          if (w_count == '0) begin
            w_done_next  = 1'b1;
            w_state_next = StDone;
          end else begin
            w_state_next = StFetch;
          end
        end
      end
      StFetch:   if (instr_valid) w_state_next = StDecode;
      StDecode:  w_state_next = StRequest;
      StRequest: w_state_next = StWait;
      StWait: begin
        // Disabled lanes never hold up the block.
        if ((lsu_waiting & r_thread_enable) == '0) w_state_next = StExecute;
      end
      StExecute: w_state_next = StUpdate;
      StUpdate: begin
        if (instr_ret) begin
          w_done_next  = 1'b1;
          w_state_next = StDone;
        end else begin
          w_pc_next    = next_pc;
          w_state_next = StFetch;
        end
      end
      StDone:    w_state_next = StDone;
      default:   w_state_next = StIdle;
    endcase
  end

  assign core_state    = r_state;
  assign thread_enable = r_thread_enable;
  assign current_pc    = r_pc;
  assign block_id      = r_block_id;
  assign done          = r_done;

`ifdef CORE_CYCLE_COUNT_EN
  logic [15:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle_count <= '0;
    end else if (r_state == StIdle) begin
      if (w_state_next != StIdle) r_cycle_count <= '0;
    end else if (r_state != StDone && r_cycle_count != 16'hFFFF) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_core_block_ctrl.sv
// Directed bench for core_block_ctrl. Scenario tasks describe each instruction as phases
// (fetch stalls, wait stalls, RET or branch) and set the expected outputs after every edge;
// a negedge process compares the DUT to those expectations each cycle.
module tb_core_block_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, instr_valid, instr_ret;
  logic [7:0] block_id_in, next_pc;
  logic [2:0] thread_count_in;
  logic [3:0] lsu_waiting;
  logic [2:0] core_state;
  logic [3:0] thread_enable;
  logic [7:0] current_pc, block_id;
  logic       done;
`ifdef CORE_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  always #5 clk = ~clk;

  core_block_ctrl #(.THREADS_PER_BLOCK(4), .PC_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .block_id_in    (block_id_in),
    .thread_count_in(thread_count_in),
    .instr_valid    (instr_valid),
    .instr_ret      (instr_ret),
    .lsu_waiting    (lsu_waiting),
    .next_pc        (next_pc),
    .core_state     (core_state),
    .thread_enable  (thread_enable),
    .current_pc     (current_pc),
    .block_id       (block_id),
`ifdef CORE_CYCLE_COUNT_EN
    .done           (done),
    .cycle_count    (cycle_count)
`else
    .done           (done)
`endif
  );

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  // Expected outputs
  logic       m_valid = 1'b0;
  int         m_state = 0;
  logic [3:0] m_te    = '0;
  logic [7:0] m_pc    = '0;
  logic [7:0] m_bid   = '0;
  logic       m_done  = 1'b0;
  int         m_cc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("core_state", 32'(core_state), 32'(m_state));
      chk("thread_enable", 32'(thread_enable), 32'(m_te));
      chk("current_pc", 32'(current_pc), 32'(m_pc));
      chk("block_id", 32'(block_id), 32'(m_bid));
      chk("done", 32'(done), 32'(m_done));
`ifdef CORE_CYCLE_COUNT_EN
      chk("cycle_count", 32'(cycle_count), 32'(m_cc));
`endif
    end
  end

  task automatic edge_wait();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Move the model to a new state; the counter runs only while busy (not IDLE/DONE).
  task automatic advance(input int ns);
    if (m_state == 0 && ns != 0) m_cc = 0;
    else if (m_state != 0 && m_state != 7 && m_cc < 65535) m_cc++;
    m_state = ns;
  endtask

  task automatic apply_reset(input logic with_start);
    reset = 1'b0;
    start = with_start;
    block_id_in = 8'hEE;
    thread_count_in = 3'd4;
    edge_wait();
    m_valid = 1'b1;
    m_state = 0; m_te = '0; m_pc = '0; m_bid = '0; m_done = 1'b0; m_cc = 0;
    reset = 1'b1;
    start = 1'b0;
    lsu_waiting = '0;
    instr_valid = 1'b0;
    instr_ret = 1'b0;
  endtask

  task automatic dispatch(input logic [7:0] id, input logic [2:0] cnt);
    int eff;
    start = 1'b1;
    block_id_in = id;
    thread_count_in = cnt;
    edge_wait();
    eff = (cnt > 4) ? 4 : int'(cnt);
    m_bid = id;
    m_te = 4'((1 << eff) - 1);
    m_pc = '0;
    if (eff == 0) begin
      m_done = 1'b1;
      advance(7);
    end else begin
      advance(1);
    end
    start = 1'b0;
    block_id_in = 8'h00;
  endtask

  // One instruction from FETCH: fstall cycles with instr_valid low, lsu mask held for up to
  // nhold WAIT cycles (stalls only if it hits an enabled lane), then RET or branch to npc.
  task automatic run_instr(input int fstall, input logic [3:0] mask, input int nhold,
                           input logic ret, input logic [7:0] npc);
    logic hit;
    instr_valid = 1'b0;
    repeat (fstall) begin
      edge_wait();
      advance(1);
    end
    instr_valid = 1'b1;
    edge_wait(); advance(2);
    instr_valid = 1'b0;
    edge_wait(); advance(3);
    lsu_waiting = mask;
    edge_wait(); advance(4);
    hit = (mask & m_te) != '0;
    if (hit) begin
      repeat (nhold) begin
        edge_wait(); advance(4);
      end
      lsu_waiting = '0;
    end
    edge_wait(); advance(5);
    lsu_waiting = '0;
    instr_ret = ret;
    next_pc = npc;
    edge_wait(); advance(6);
    edge_wait();
    if (ret) begin
      m_done = 1'b1;
      advance(7);
    end else begin
      m_pc = npc;
      advance(1);
    end
    instr_ret = 1'b0;
  endtask

  initial begin
    int e0;
    reset = 1'b1; start = 1'b0; block_id_in = '0; thread_count_in = '0;
    instr_valid = 1'b0; instr_ret = 1'b0; lsu_waiting = '0; next_pc = '0;
    edge_wait();

    // Reset state
    apply_reset(1'b0);
    chk("rst_state", 32'(core_state), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Single RET instruction, 3 lanes
    e0 = edges;
    dispatch(8'd5, 3'd3);
    run_instr(0, 4'b0000, 0, 1'b1, 8'h00);
    chk("r033_latency", 32'(edges - e0 - 1), 32'd6);
    chk("r033_block_id", 32'(block_id), 32'd5);
    chk("r033_te", 32'(thread_enable), 32'b0111);
    chk("r033_done", 32'(done), 32'd1);
`ifdef CORE_CYCLE_COUNT_EN
    chk("r038_cc", 32'(cycle_count), 32'd6);
`endif

    // DONE is terminal even with start asserted
    start = 1'b1; block_id_in = 8'h77; thread_count_in = 3'd1;
    repeat (3) begin
      edge_wait(); advance(7);
    end
    start = 1'b0;
    chk("done_hold_state", 32'(core_state), 32'd7);
    chk("done_hold_bid", 32'(block_id), 32'd5);
`ifdef CORE_CYCLE_COUNT_EN
    chk("r038_cc_hold", 32'(cycle_count), 32'd6);
`endif

    // Clamp, fetch stall, branch, start ignored while busy
    apply_reset(1'b0);
    dispatch(8'd9, 3'd7);
    chk("r034_te", 32'(thread_enable), 32'b1111);
    start = 1'b1; block_id_in = 8'hAA; thread_count_in = 3'd1;
    run_instr(0, 4'b0000, 0, 1'b0, 8'h12);
    chk("r036_pc", 32'(current_pc), 32'h12);
    chk("r036_state", 32'(core_state), 32'd1);
    run_instr(4, 4'b1000, 2, 1'b0, 8'hFF);
    chk("busy_bid", 32'(block_id), 32'd9);
    start = 1'b0;
    run_instr(1, 4'b0000, 0, 1'b1, 8'h00);
    chk("pc_ff_kept", 32'(current_pc), 32'hFF);

    // Masked lanes ignored; enabled lane stalls WAIT
    apply_reset(1'b0);
    dispatch(8'd2, 3'd2);
    run_instr(0, 4'b0100, 3, 1'b0, 8'h40);
    run_instr(0, 4'b0010, 3, 1'b1, 8'h00);
`ifdef CORE_CYCLE_COUNT_EN
    chk("cc_two_instr", 32'(cycle_count), 32'd15);
`endif

    // Reset mid-WAIT wins over start
    apply_reset(1'b0);
    dispatch(8'd3, 3'd2);
    instr_valid = 1'b1;
    edge_wait(); advance(2);
    instr_valid = 1'b0;
    edge_wait(); advance(3);
    lsu_waiting = 4'b0010;
    edge_wait(); advance(4);
    edge_wait(); advance(4);
    apply_reset(1'b1);
    chk("r037_state", 32'(core_state), 32'd0);
    chk("r037_done", 32'(done), 32'd0);
    chk("r037_te", 32'(thread_enable), 32'd0);
    edge_wait();

    // Zero-thread block goes straight to DONE
    dispatch(8'd7, 3'd0);
    chk("r019_state", 32'(core_state), 32'd7);
    chk("r019_done", 32'(done), 32'd1);
    chk("r019_te", 32'(thread_enable), 32'd0);
    edge_wait(); advance(7);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_block_ctrl.md
CORE_BLOCK_CTRL -- requirements
Module: core_block_ctrl

Interface
REQ-001 SHALL have parameter THREADS_PER_BLOCK, default 4, meaning the number of thread lanes per core.
REQ-002 SHALL have parameter PC_WIDTH, default 8, meaning the program counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (reset==0 resets).
REQ-005 SHALL have port start, input, 1 bit: block dispatch request from the dispatcher.
REQ-006 SHALL have port block_id_in, input, 8 bits: block index for this dispatch.
REQ-007 SHALL have port thread_count_in, input, $clog2(THREADS_PER_BLOCK)+1 bits: active threads in the block.
REQ-008 SHALL have port instr_valid, input, 1 bit: fetcher has delivered the instruction at current_pc.
REQ-009 SHALL have port instr_ret, input, 1 bit: the decoded instruction is RET.
REQ-010 SHALL have port lsu_waiting, input, THREADS_PER_BLOCK bits: per-lane memory operation outstanding.
REQ-011 SHALL have port next_pc, input, PC_WIDTH bits: PC computed by the branch unit.
REQ-012 SHALL have port core_state, output, 3 bits: current FSM state encoding.
REQ-013 SHALL have port thread_enable, output, THREADS_PER_BLOCK bits: active lane mask.
REQ-014 SHALL have port current_pc, output, PC_WIDTH bits: PC of the instruction in flight.
REQ-015 SHALL have port block_id, output, 8 bits: latched block index.
REQ-016 SHALL have port done, output, 1 bit: block complete, returned to the dispatcher.

Function
REQ-017 SHALL encode states as IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
REQ-018 In IDLE with start=1, SHALL latch block_id_in, clamp thread_count_in to THREADS_PER_BLOCK, set current_pc=0, set thread_enable low bits = count, and enter FETCH the next cycle.
REQ-019 In IDLE with start=1 and thread_count_in=0, SHALL enter DONE directly with done=1 and thread_enable=0.
REQ-020 FETCH SHALL hold until instr_valid=1, then enter DECODE.
REQ-021 DECODE and REQUEST SHALL each last exactly one cycle, advancing DECODE->REQUEST->WAIT.
REQ-022 WAIT SHALL hold while (lsu_waiting & thread_enable) is nonzero, then enter EXECUTE; lanes with thread_enable=0 are ignored.
REQ-023 EXECUTE SHALL last one cycle, then enter UPDATE.
REQ-024 UPDATE with instr_ret=1 SHALL enter DONE and assert done in the same edge; otherwise it SHALL load current_pc=next_pc and enter FETCH.
REQ-025 Minimum instruction latency SHALL be 6 cycles (FETCH with instr_valid already high through UPDATE).
REQ-026 DONE SHALL be terminal: done stays 1 and all outputs hold until reset, regardless of start.
REQ-027 start SHALL be ignored in every state other than IDLE; block_id and thread_enable change only on the IDLE->FETCH or IDLE->DONE transition.
REQ-028 current_pc SHALL wrap modulo 2^PC_WIDTH with no error indication.

Reset
REQ-029 With reset=0 at a rising edge, SHALL set core_state=IDLE, thread_enable=0, current_pc=0, block_id=0, done=0, regardless of state, including mid-instruction.
REQ-030 reset SHALL take priority over start and all other inputs in the same cycle.

Configuration
REQ-031 When macro CORE_CYCLE_COUNT_EN is defined, SHALL add output cycle_count (16 bits): reset to 0, cleared on leaving IDLE, incremented each cycle the FSM is outside IDLE and DONE, saturating at 16'hFFFF, frozen in DONE.
REQ-032 When CORE_CYCLE_COUNT_EN is undefined, the cycle_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 start=1, block_id_in=5, thread_count_in=3, instr_valid=1, instr_ret=1 on first UPDATE -> block_id=5, thread_enable=4'b0111, done=1 six cycles after leaving IDLE.
REQ-034 thread_count_in=7 with THREADS_PER_BLOCK=4 -> thread_enable=4'b1111.
REQ-035 thread_count_in=2, lsu_waiting=4'b0100 held -> WAIT does not stall; lsu_waiting=4'b0010 for 3 cycles -> WAIT lasts 3 extra cycles.
REQ-036 next_pc=8'h12 at first UPDATE with instr_ret=0 -> current_pc=8'h12 in FETCH; instr_valid low 4 cycles -> FETCH holds 4 cycles.
REQ-037 reset=0 asserted during WAIT -> next cycle core_state=0, done=0, thread_enable=0; start=1 while in DONE -> no state change.
REQ-038 With CORE_CYCLE_COUNT_EN defined, the REQ-033 run -> cycle_count=6 and holds in DONE.
